fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Front-end stage of the CPU pipeline; transmitter side of the fetch->decode interface.
//  Owns the fetch PC, issues word reads to instruction memory and buffers returned words.
//  Presents {ftch_dec_instr, ftch_dec_pc} to decode with a valid/ready handshake.
//  Applies redirects (taken branch/jump) from exec by flushing and restarting at a new PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC loaded on reset
//  BUF_DEPTH  2              instruction buffer entries (power of two, >=2)
// PORTS
//  clk             in   1   system clock, all state on posedge
//  rst             in   1   asynchronous, active-high reset
//  imem_req        out  1   single-cycle read request to instruction memory
//  imem_addr       out  32  word-aligned read address, valid while imem_req=1
//  imem_ack        in   1   read data valid; exactly one ack per request, >=1 cycle after req
//  imem_rdata      in   32  instruction word, valid while imem_ack=1
//  redirect        in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new fetch PC; bits [1:0] ignored (forced to 0)
//  dec_ftch_ready  in   1   decode accepts the head entry this cycle
//  ftch_dec_valid  out  1   head entry valid
//  ftch_dec_instr  out  32  head instruction word
//  ftch_dec_pc     out  32  PC of head instruction
// BEHAVIOUR
//  Reset: state=ISSUE, fetch_pc=RESET_PC, buffer empty; imem_req=0, ftch_dec_valid=0,
//   ftch_dec_instr=32'h0000_0013 (NOP), ftch_dec_pc=RESET_PC.
//  At most one outstanding imem request. FSM states: ISSUE, WAIT, DROP.
//   ISSUE: imem_req=1, imem_addr=fetch_pc when count<BUF_DEPTH and !redirect;
//          on req: fetch_pc<=fetch_pc+4, ->WAIT. imem_ack in ISSUE is ignored.
//   WAIT:  on imem_ack and !redirect: push {fetch addr, imem_rdata}; if
//          count+1-pop < BUF_DEPTH, issue the next request in the same cycle
//          (imem_req=1, fetch_pc+=4, stay WAIT); otherwise ->ISSUE.
//          on redirect without ack: ->DROP. On redirect with ack: discard data, ->ISSUE.
//   DROP:  wait for the stale ack and discard it, then ->ISSUE. A further redirect in DROP
//          only updates fetch_pc.
//  Redirect (any state): buffer flushed (ftch_dec_valid=0 next cycle),
//   fetch_pc<={redirect_pc[31:2],2'b00}. Redirect has priority over push, pop and issue.
//   No imem_req is issued in the redirect cycle.
//  Output: ftch_dec_valid = count!=0; instr/pc = buffer head (registered storage).
//   When empty: instr=NOP 32'h13; pc holds its last value.
//   Pop when valid && ready. While valid && !ready, instr/pc are held stable.
//   A push and a pop in the same cycle leave count unchanged. Order is strictly FIFO.
//  Latency: ack at cycle N -> ftch_dec_valid at N+1 (if buffer was empty).
//   Redirect at N from ISSUE/idle -> imem_req with the new PC at N+1.
//  Throughput: 1 instr/cycle with a 1-cycle-latency memory and decode always ready.
//  PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 without fault.
//  Buffer full: no request issued; fetch_pc held; resumes the cycle after a pop.
//  Reset mid-operation: all state cleared immediately. A late ack for a pre-reset request
//   arrives in ISSUE and is ignored.
// TESTING
//  1 Reset release, 1-cycle memory returning addr-derived words, ready=1 -> reqs to
//    0x0,0x4,0x8 on consecutive cycles; decode sees pc 0x0,0x4,0x8 with matching instr.
//  2 ready=0 for 5 cycles after the first valid -> buffer fills to 2 and imem_req drops;
//    head (pc 0x0) stays stable; on ready=1, pc 0x0,0x4,0x8 arrive in order, none lost.
//  3 redirect=1, redirect_pc=0x100 while in WAIT with 3-cycle latency -> stale ack dropped;
//    next imem_addr=0x100; first valid after flush has pc=0x100.
//  4 redirect coincident with imem_ack and ready=1 -> ack data discarded, no pop counted;
//    valid=0 next cycle; imem_req for redirect_pc on the following cycle.
//  5 redirect_pc=0xFFFF_FFFB -> fetch at 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
//  6 rst pulsed while a request is in flight, ack arrives after release -> ack ignored;
//    first imem_addr=RESET_PC; valid=0 until that request's ack.

Source files
------------

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: owns the fetch PC, keeps one instruction-memory read in flight
// and queues returned words in a small FIFO that feeds decode through a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ftch_ready,
    output logic        ftch_dec_valid,
    output logic [31:0] ftch_dec_instr,
    output logic [31:0] ftch_dec_pc
);

    localparam int unsigned PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               valid_q, valid_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        buf_instr_q [BUF_DEPTH];
    logic [31:0]        buf_pc_q    [BUF_DEPTH];

    logic               pop_en;
    logic               push_en;
    logic               issue_en;
    logic [CNT_W-1:0]   cnt_pushpop;
    logic               unused_rpc_low;

    // Low redirect PC bits are dropped: fetch is always word aligned.
    assign unused_rpc_low = ^redirect_pc[1:0];

    // Handshake decisions; redirect overrides push, pop and issue.
    always_comb begin
        pop_en      = valid_q && dec_ftch_ready && !redirect;
        push_en     = (state_q == ST_WAIT) && imem_ack && !redirect;
        cnt_pushpop = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        issue_en    = 1'b0;
        case (state_q)
            ST_ISSUE: issue_en = (count_q < DEPTH_C) && !redirect;
            ST_WAIT:  issue_en = push_en && (cnt_pushpop < DEPTH_C);
            default:  issue_en = 1'b0;
        endcase
        issue_en = issue_en && !rst;
    end

    assign imem_req       = issue_en;
    assign imem_addr      = fetch_pc_q;
    assign ftch_dec_valid = valid_q;
    assign ftch_dec_instr = instr_q;
    assign ftch_dec_pc    = pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;

        case (state_q)
            ST_ISSUE: if (issue_en) state_d = ST_WAIT;
            ST_WAIT: begin
                if (redirect)      state_d = imem_ack ? ST_ISSUE : ST_DROP;
                else if (imem_ack) state_d = issue_en ? ST_WAIT : ST_ISSUE;
            end
            ST_DROP:  if (imem_ack) state_d = ST_ISSUE;
            default:  state_d = ST_ISSUE;
        endcase

        if (issue_en) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_pc_d  = fetch_pc_q;
        end

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            count_d = cnt_pushpop;
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Head registers track the entry at rd_ptr_d; a push into an empty buffer bypasses storage.
        valid_d = (count_d != '0);
        instr_d = NOP;
        if (count_d != '0) begin
            if ((count_q - CNT_W'(pop_en)) == '0) begin
                instr_d = imem_rdata;
                pc_d    = pend_pc_q;
            end else begin
                instr_d = buf_instr_q[rd_ptr_d];
                pc_d    = buf_pc_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ISSUE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[PTR_W'(i)] <= '0;
                buf_pc_q[PTR_W'(i)]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            if (push_en) begin
                buf_instr_q[wr_ptr_q] <= imem_rdata;
                buf_pc_q[wr_ptr_q]    <= pend_pc_q;
            end
        end
    end

endmodule
